// File: rtl/rx_sr.sv
// Serial-to-parallel receiver: collects NUM_BITS sampled bits into a word and
// hands it to a consumer through a ready/read handshake with overrun detection.
module rx_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                rising_edge_found,
    input  logic                rx_enable,
    input  logic                rx_in,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                busy
);
    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic [NUM_BITS-1:0] sr, sr_nxt;
    logic                sample;
    logic                load_ok;
    logic                ovr_set;

    assign sample = rising_edge_found & rx_enable;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sr_nxt    = sr;
        if (sample) begin
            if (SHIFT_MSB) sr_nxt = {sr[NUM_BITS-2:0], rx_in};
            else           sr_nxt = {rx_in, sr[NUM_BITS-1:1]};
        end
        case (state)
            IDLE, SHIFT: begin
                if (sample) begin
                    count_nxt = count + CW'(1);
                    state_nxt = (count_nxt == CW'(NUM_BITS)) ? LOAD : SHIFT;
                end
            end
            LOAD: begin
                // a sample in the hand-off cycle starts the next word
                count_nxt = sample ? CW'(1) : '0;
                state_nxt = sample ? SHIFT : IDLE;
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        if (!rx_enable) begin
            count_nxt = '0;
            state_nxt = IDLE;
        end
        load_ok = (state == LOAD) && (!data_ready || data_read);
        ovr_set = (state == LOAD) && data_ready && !data_read;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            count         <= '0;
            sr            <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            sr    <= sr_nxt;
            busy  <= (state_nxt == SHIFT);
            if (load_ok) rx_data <= sr;
            if (load_ok)        data_ready <= 1'b1;
            else if (data_read) data_ready <= 1'b0;
            if (ovr_set)        overrun_error <= 1'b1;
            else if (data_read) overrun_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_sr.sv
// Bench for rx_sr: MSB-first and LSB-first instances against a word-level model.
module tb_rx_sr;
    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       rising_edge_found = 1'b0;
    logic       rx_enable = 1'b0;
    logic       rx_in = 1'b0;
    logic       data_read = 1'b0;
    logic [7:0] rx_data0, rx_data1;
    logic       dr0, dr1, ovr0, ovr1, busy0, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: bits collected toward the current word, last completed word
    int         m_nbits = 0;
    bit         m_pend = 0;
    logic [7:0] m_w0 = 0, m_w1 = 0, m_done0 = 0, m_done1 = 0;
    logic [7:0] m_data0 = 0, m_data1 = 0;
    bit         m_dr = 0, m_ovr = 0, m_busy = 0;

    always #5 clk = ~clk;

    rx_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u0 (
        .clk(clk), .n_rst(n_rst), .rising_edge_found(rising_edge_found),
        .rx_enable(rx_enable), .rx_in(rx_in), .data_read(data_read),
        .rx_data(rx_data0), .data_ready(dr0), .overrun_error(ovr0), .busy(busy0)
    );

    rx_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u1 (
        .clk(clk), .n_rst(n_rst), .rising_edge_found(rising_edge_found),
        .rx_enable(rx_enable), .rx_in(rx_in), .data_read(data_read),
        .rx_data(rx_data1), .data_ready(dr1), .overrun_error(ovr1), .busy(busy1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nbits = 0; m_pend = 0; m_w0 = 0; m_w1 = 0; m_done0 = 0; m_done1 = 0;
        m_data0 = 0; m_data1 = 0; m_dr = 0; m_ovr = 0; m_busy = 0;
    endtask

    task automatic model_step();
        bit set_ovr;
        set_ovr = 0;
        if (m_pend) begin
            if (!m_dr || data_read) begin
                m_data0 = m_done0;
                m_data1 = m_done1;
                m_dr    = 1;
            end else begin
                set_ovr = 1;
            end
        end else if (data_read) begin
            m_dr = 0;
        end
        m_pend = 0;
        if (set_ovr)        m_ovr = 1;
        else if (data_read) m_ovr = 0;
        if (!rx_enable) begin
            m_nbits = 0;
        end else if (rising_edge_found) begin
            if (m_nbits == 0) begin m_w0 = 0; m_w1 = 0; end
            m_w0 = 8'((m_w0 * 2 + rx_in) % 256);
            m_w1 = 8'(m_w1 + (rx_in << m_nbits));
            m_nbits++;
            if (m_nbits == 8) begin
                m_done0 = m_w0;
                m_done1 = m_w1;
                m_pend  = 1;
                m_nbits = 0;
            end
        end
        m_busy = (m_nbits != 0);
    endtask

    task automatic compare_all();
        check("rx_data_msb", rx_data0, m_data0);
        check("rx_data_lsb", rx_data1, m_data1);
        check("data_ready_msb", {7'b0, dr0}, {7'b0, m_dr});
        check("data_ready_lsb", {7'b0, dr1}, {7'b0, m_dr});
        check("overrun_msb", {7'b0, ovr0}, {7'b0, m_ovr});
        check("overrun_lsb", {7'b0, ovr1}, {7'b0, m_ovr});
        check("busy_msb", {7'b0, busy0}, {7'b0, m_busy});
        check("busy_lsb", {7'b0, busy1}, {7'b0, m_busy});
    endtask

    // inputs change at the falling edge; outputs are compared at the next falling edge
    task automatic cycle(input bit ren, input bit rise, input bit din, input bit rd);
        rx_enable = ren; rising_edge_found = rise; rx_in = din; data_read = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) cycle(1, 1, w[i], 0);
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        #1;
        check("rst_rx_data_msb", rx_data0, 8'h00);
        check("rst_rx_data_lsb", rx_data1, 8'h00);
        check("rst_flags", {4'b0, dr0, ovr0, busy0, dr1 | ovr1 | busy1}, 8'h00);
        model_reset();
        #2;
        n_rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        pulse_reset();
        cycle(1, 0, 0, 0);

        // A5 with the two-edge latency
        send(8'hA5);
        check("a5_not_ready_yet", {7'b0, dr0}, 8'h00);
        cycle(1, 0, 0, 0);
        check("a5_ready", {7'b0, dr0}, 8'h01);
        check("a5_data", rx_data0, 8'hA5);
        check("a5_busy", {7'b0, busy0}, 8'h00);
        cycle(1, 0, 0, 1);

        // overrun: 3C unread, then C3
        send(8'h3C); cycle(1, 0, 0, 0);
        send(8'hC3); cycle(1, 0, 0, 0);
        check("ovr_data", rx_data0, 8'h3C);
        check("ovr_flag", {7'b0, ovr0}, 8'h01);
        cycle(1, 0, 0, 1);
        check("ovr_read_clears", {6'b0, dr0, ovr0}, 8'h00);

        // read in the LOAD cycle of 0F while F0 is unread
        send(8'hF0); cycle(1, 0, 0, 0);
        send(8'h0F); cycle(1, 0, 0, 1);
        check("rd_in_load_data", rx_data0, 8'h0F);
        check("rd_in_load_flags", {6'b0, dr0, ovr0}, 8'h02);
        cycle(1, 0, 0, 1);

        // partial word abandoned by rx_enable low
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 0);
        send(8'h81); cycle(1, 0, 0, 0);
        check("abandon_data", rx_data0, 8'h81);
        cycle(1, 0, 0, 1);

        // back-to-back words: first bit of FF lands in the LOAD cycle of 96
        send(8'h96);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 1, i == 1);
            if (i == 0) check("b2b_first", rx_data0, 8'h96);
        end
        cycle(1, 0, 0, 0);
        check("b2b_second", rx_data0, 8'hFF);
        check("b2b_flags", {6'b0, dr0, ovr0}, 8'h02);
        cycle(1, 0, 0, 1);

        // reset mid-word, then 5A on both bit orders
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0);
        pulse_reset();
        send(8'h5A); cycle(1, 0, 0, 0);
        check("after_rst_msb", rx_data0, 8'h5A);
        check("after_rst_lsb", rx_data1, 8'h5A);
        cycle(1, 0, 0, 1);
        send(8'h01); cycle(1, 0, 0, 1);
        check("lsb_order", rx_data1, 8'h80);

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 699) == 0) pulse_reset();
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
